seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 117 +++++++++++
 tb/tb_seq_divider.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH steps per operation.
// A zero divisor short-circuits straight to DONE with all-ones quotient and flag set.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] sub;
  logic [WIDTH:0]   next_rem;
  logic [WIDTH-1:0] next_dvd;

  // The dividend register doubles as the quotient shift register: the dividend
  // MSB moves into the remainder while the new quotient bit enters at the LSB.
  always_comb begin
    shifted  = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
    sub      = {1'b0, shifted} - {2'b00, dsr_q};
    next_rem = sub[WIDTH+1] ? shifted : sub[WIDTH:0];
    next_dvd = {dvd_q[WIDTH-2:0], ~sub[WIDTH+1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dvd_d = dividend;
          dsr_d = divisor;
          rem_d = '0;
          if (divisor == '0) begin
            state_d = DONE;
            cnt_d   = '0;
            quo_d   = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = CW'(WIDTH);
          end
        end
      end
      RUN: begin
        rem_d = next_rem;
        dvd_d = next_dvd;
        cnt_d = cnt_q - CW'(1);
        // Last step publishes directly so results never pass through RUN values.
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quo_d   = next_dvd;
          rmd_d   = next_rem[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: a cycle-level model built on "result due N edges after
// acceptance" checks every cycle; directed runs pin literal results and latencies.
module tb_seq_divider;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Model: an accepted request is due W edges later (0 for a zero divisor).
  int           k   = 0;
  int           due = -1;
  logic         act = 1'b0;
  logic [W-1:0] pq = '0, pr = '0;
  logic         pz = 1'b0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_z = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0;

  always @(posedge clk or posedge rst) begin
    int           nd;
    logic         na, nz;
    logic [W-1:0] nq, nr;
    if (rst) begin
      k <= 0; due <= -1; act <= 1'b0; pq <= '0; pr <= '0; pz <= 1'b0;
      m_busy <= 1'b0; m_done <= 1'b0; m_q <= '0; m_r <= '0; m_z <= 1'b0;
    end else begin
      nd = due; na = act; nq = pq; nr = pr; nz = pz;
      if (start && !m_busy) begin
        na = 1'b1;
        nd = k + ((divisor == 0) ? 0 : W);
        if (divisor == 0) begin
          nq = '1; nr = dividend; nz = 1'b1;
        end else begin
          nq = dividend / divisor; nr = dividend % divisor; nz = 1'b0;
        end
      end
      m_busy <= na && (k < nd);
      m_done <= na && (k == nd);
      if (na && k == nd) begin
        m_q <= nq; m_r <= nr; m_z <= nz;
        na = 1'b0;
      end
      act <= na; due <= nd; pq <= nq; pr <= nr; pz <= nz;
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
      chk("div_by_zero", div_by_zero, m_z);
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  // Caller is at negedge+1; start is presented for exactly one edge.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input int eq, input int er, input int ez, input int ebusy,
                     input string nm);
    int busy_cnt, edges;
    bit seen;
    start = 1'b1; dividend = a; divisor = b;
    tick();
    start = 1'b0;
    busy_cnt = 0; edges = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin seen = 1'b1; edges = i; break; end
      if (busy) busy_cnt++;
      tick();
    end
    chk({nm, "_done_seen"}, seen, 1);
    chk({nm, "_done_edge"}, edges, ebusy);
    chk({nm, "_busy_cycles"}, busy_cnt, ebusy);
    chk({nm, "_q"}, quotient, eq);
    chk({nm, "_r"}, remainder, er);
    chk({nm, "_dbz"}, div_by_zero, ez);
    chk({nm, "_model_q"}, m_q, eq);
  endtask

  initial begin
    int pulses;
    tick(); tick();
    chk("reset_q", quotient, 0);
    chk("reset_r", remainder, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", div_by_zero, 0);
    rst = 1'b0;
    armed = 1'b1;
    tick();

    run(8'd100, 8'd7,   14,  2, 0, 8, "100div7");
    tick();
    run(8'd255, 8'd1,  255,  0, 0, 8, "255div1");
    tick();
    run(8'd3,   8'd10,   0,  3, 0, 8, "3div10");
    tick();
    run(8'd200, 8'd200,  1,  0, 0, 8, "200div200");
    tick();
    run(8'd5,   8'd0,  255,  5, 1, 0, "5div0");
    tick();
    run(8'd0,   8'd9,    0,  0, 0, 8, "0div9");
    tick();

    // Start while busy must be ignored.
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; dividend = 8'd50; divisor = 8'd3;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        chk("ignore_q", quotient, 14);
        chk("ignore_r", remainder, 2);
      end
      tick();
    end
    chk("ignore_pulses", pulses, 1);

    // Reset three cycles into RUN aborts the operation.
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      tick();
    end
    chk("abort_no_done", pulses, 0);
    run(8'd9, 8'd2, 4, 1, 0, 8, "9div2");

    // Back-to-back: start presented during the DONE cycle.
    run(8'd17, 8'd5, 3, 2, 0, 8, "17div5_b2b");
    run(8'd7, 8'd0, 255, 7, 1, 0, "7div0_b2b");
    run(8'd250, 8'd16, 15, 10, 0, 8, "250div16_b2b");
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
